// File: rtl/circle_ctrl.sv
// Run/pause/stop sequencing and speed control for the circle stepper.
// Ports: clk_i, rst_ni, btn_*_i, auto_i, row_i -> run_o, clear_o, speed_o, lap_count_o, state_o.
module circle_ctrl #(
  parameter int unsigned LONG_PRESS     = 100_000_000,
  parameter int unsigned LAPS_PER_LEVEL = 4,
  parameter int unsigned LAP_WIDTH      = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 btn_start_i,
  input  logic                 btn_up_i,
  input  logic                 btn_down_i,
  input  logic                 auto_i,
  input  logic                 row_i,
  output logic                 run_o,
  output logic                 clear_o,
  output logic [2:0]           speed_o,
  output logic [LAP_WIDTH-1:0] lap_count_o,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  localparam int PW = $clog2(LONG_PRESS + 1);
  localparam int LW = (LAPS_PER_LEVEL > 1) ? $clog2(LAPS_PER_LEVEL) : 1;
  localparam logic [PW-1:0] LP_MAX = PW'(LONG_PRESS);
  localparam logic [PW-1:0] LP_M1  = PW'(LONG_PRESS - 1);
  localparam logic [LW-1:0] LV_MAX = LW'(LAPS_PER_LEVEL - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_start_q;
  logic                 r_up_q;
  logic                 r_down_q;
  logic                 r_row_q;
  logic [PW-1:0]        r_press;
  logic [LW-1:0]        r_level;
  logic [LAP_WIDTH-1:0] r_lap;
  logic [2:0]           r_speed;
  logic [2:0]           w_speed_nxt;
  logic                 r_run;
  logic                 r_clear;
  logic                 w_restart;
  logic                 w_to_idle;

  logic w_short;
  logic w_long;
  logic w_up;
  logic w_down;
  logic w_lap;
  logic w_lvl_wrap;
  logic w_auto;
  logic w_inc;

  // The falling edge ending a long press sees a saturated counter.
  assign w_short    = r_start_q & ~btn_start_i & (r_press < LP_MAX);
  assign w_long     = btn_start_i & (r_press == LP_M1);
  assign w_up       = btn_up_i & ~r_up_q;
  assign w_down     = btn_down_i & ~r_down_q;
  assign w_lap      = row_i & ~r_row_q & (r_state == S_RUN);
  assign w_lvl_wrap = w_lap & (r_level == LV_MAX);
  assign w_auto     = w_lvl_wrap & auto_i;
  assign w_inc      = w_up | w_auto;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    w_to_idle   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_short) begin
          w_state_nxt = S_RUN;
          w_restart   = 1'b1;
        end
      end
      S_RUN: begin
        if (w_long) begin
          w_state_nxt = S_IDLE;
          w_to_idle   = 1'b1;
        end else if (w_short) begin
          w_state_nxt = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (w_long) begin
          w_state_nxt = S_IDLE;
          w_to_idle   = 1'b1;
        end else if (w_short) begin
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Up and auto-up merge into one +1; down cancels it.
  always_comb begin
    w_speed_nxt = r_speed;
    if (w_inc && !w_down && r_speed != 3'd7)
      w_speed_nxt = r_speed + 3'd1;
    else if (w_down && !w_inc && r_speed != 3'd0)
      w_speed_nxt = r_speed - 3'd1;
    if (w_to_idle)
      w_speed_nxt = 3'd0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_start_q <= 1'b0;
      r_up_q    <= 1'b0;
      r_down_q  <= 1'b0;
      r_row_q   <= 1'b0;
      r_press   <= '0;
      r_level   <= '0;
      r_lap     <= '0;
      r_speed   <= 3'd0;
      r_run     <= 1'b0;
      r_clear   <= 1'b0;
    end else begin
      r_start_q <= btn_start_i;
      r_up_q    <= btn_up_i;
      r_down_q  <= btn_down_i;
      r_row_q   <= row_i;
      if (!btn_start_i)
        r_press <= '0;
      else if (r_press != LP_MAX)
        r_press <= r_press + PW'(1);
      r_speed <= w_speed_nxt;
      r_run   <= (w_state_nxt == S_RUN);
      r_clear <= w_restart;
      if (w_restart) begin
        r_lap   <= '0;
        r_level <= '0;
      end else if (w_lap) begin
        r_lap   <= r_lap + LAP_WIDTH'(1);
        r_level <= w_lvl_wrap ? '0 : r_level + LW'(1);
      end
    end
  end

  assign run_o       = r_run;
  assign clear_o     = r_clear;
  assign speed_o     = r_speed;
  assign lap_count_o = r_lap;
  assign state_o     = r_state;

endmodule

// File: tb/tb_circle_ctrl.sv
// Bench for circle_ctrl: directed scenarios plus random buttons,
// all checked every cycle against a behavioural model.
module tb_circle_ctrl;

  localparam int LP  = 8;
  localparam int LPL = 2;
  localparam int LAW = 3;

  logic           clk = 0;
  logic           rst_n = 0;
  logic           start = 0;
  logic           up = 0;
  logic           dn = 0;
  logic           auto_e = 0;
  logic           row = 0;
  logic           run_o;
  logic           clear_o;
  logic [2:0]     speed_o;
  logic [LAW-1:0] lap_o;
  logic [1:0]     state_o;

  int checks = 0;
  int failures = 0;
  int clr_cnt = 0;
  bit chk_en = 0;

  // model state: 0 idle, 1 run, 2 pause
  int m_state = 0;
  int m_speed = 0;
  int m_lap = 0;
  int m_level = 0;
  int m_press = 0;
  int m_clear = 0;
  bit p_start = 0;
  bit p_up = 0;
  bit p_dn = 0;
  bit p_row = 0;

  circle_ctrl #(
    .LONG_PRESS(LP),
    .LAPS_PER_LEVEL(LPL),
    .LAP_WIDTH(LAW)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .btn_start_i(start),
    .btn_up_i(up),
    .btn_down_i(dn),
    .auto_i(auto_e),
    .row_i(row),
    .run_o(run_o),
    .clear_o(clear_o),
    .speed_o(speed_o),
    .lap_count_o(lap_o),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit sh, lg, upe, dne, aup;
    int d;
    if (!rst_n) begin
      m_state = 0; m_speed = 0; m_lap = 0; m_level = 0;
      m_press = 0; m_clear = 0;
      p_start = 0; p_up = 0; p_dn = 0; p_row = 0;
    end else begin
      sh  = p_start && !start && (m_press < LP);
      lg  = start && (m_press + 1 == LP);
      upe = up && !p_up;
      dne = dn && !p_dn;
      aup = 0;
      m_clear = 0;
      if (row && !p_row && m_state == 1) begin
        m_lap = (m_lap + 1) % (1 << LAW);
        m_level++;
        if (m_level == LPL) begin
          m_level = 0;
          aup = auto_e;
        end
      end
      d = ((upe || aup) ? 1 : 0) - (dne ? 1 : 0);
      m_speed = m_speed + d;
      if (m_speed > 7) m_speed = 7;
      if (m_speed < 0) m_speed = 0;
      if (m_state == 0 && sh) begin
        m_state = 1; m_clear = 1; m_lap = 0; m_level = 0;
      end else if (m_state != 0 && lg) begin
        m_state = 0; m_speed = 0;
      end else if (sh) begin
        m_state = (m_state == 1) ? 2 : 1;
      end
      m_press = start ? ((m_press < LP) ? m_press + 1 : LP) : 0;
      p_start = start; p_up = up; p_dn = dn; p_row = row;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", state_o, m_state);
      chk("run", run_o, (m_state == 1) ? 1 : 0);
      chk("clear", clear_o, m_clear);
      chk("speed", speed_o, m_speed);
      chk("lap", lap_o, m_lap);
    end
    if (clear_o === 1'b1) clr_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int n);
    start = 1;
    cyc(n);
    start = 0;
    cyc(1);
  endtask

  task automatic pulse_up();
    up = 1; cyc(1); up = 0; cyc(1);
  endtask

  task automatic pulse_dn();
    dn = 1; cyc(1); dn = 0; cyc(1);
  endtask

  task automatic pulse_row(input int n);
    repeat (n) begin
      row = 1; cyc(1); row = 0; cyc(1);
    end
  endtask

  initial begin
    cyc(2);
    chk_en = 1;
    chk("rst_state", state_o, 0);
    chk("rst_speed", speed_o, 0);
    chk("rst_lap", lap_o, 0);
    chk("rst_run", run_o, 0);
    rst_n = 1;
    cyc(1);

    // 1: start
    clr_cnt = 0;
    press(3);
    chk("t1_state", state_o, 1);
    chk("t1_run", run_o, 1);
    chk("t1_clear", clear_o, 1);
    cyc(3);
    chk("t1_clr_cnt", clr_cnt, 1);
    chk("t1_speed", speed_o, 0);

    // 2: pause / resume
    press(3);
    chk("t2_pause", state_o, 2);
    chk("t2_run0", run_o, 0);
    clr_cnt = 0;
    press(3);
    chk("t2_resume", state_o, 1);
    cyc(2);
    chk("t2_noclr", clr_cnt, 0);
    chk("t2_lap", lap_o, 0);

    // 3: manual speed
    for (int i = 0; i < 9; i++) begin
      pulse_up();
      chk("t3_up", speed_o, (i < 7) ? i + 1 : 7);
    end
    up = 1; dn = 1; cyc(1); up = 0; dn = 0; cyc(1);
    chk("t3_both", speed_o, 7);
    for (int i = 0; i < 8; i++) pulse_dn();
    chk("t3_down", speed_o, 0);

    // 4: laps and auto acceleration
    auto_e = 1;
    pulse_row(5);
    chk("t4_lap5", lap_o, 5);
    chk("t4_spd2", speed_o, 2);
    press(3);
    pulse_row(4);
    chk("t4_plap", lap_o, 5);
    chk("t4_pspd", speed_o, 2);
    press(3);
    pulse_row(3);
    chk("t4_wrap", lap_o, 0);
    chk("t4_spd4", speed_o, 4);
    pulse_row(1);

    // 5: long press
    start = 1;
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      if (i == 7) chk("t5_still", state_o, 1);
      if (i == 8) begin
        chk("t5_idle", state_o, 0);
        chk("t5_spd0", speed_o, 0);
        chk("t5_lap", lap_o, 1);
      end
    end
    start = 0;
    cyc(3);
    chk("t5_rel", state_o, 0);
    press(12);
    cyc(2);
    chk("t5_idle_lp", state_o, 0);

    // 6: reset mid-run with start held
    press(3);
    chk("t6_run", state_o, 1);
    start = 1;
    cyc(2);
    rst_n = 0;
    cyc(1);
    chk("t6_rst_state", state_o, 0);
    chk("t6_rst_run", run_o, 0);
    rst_n = 1;
    start = 0;
    cyc(4);
    chk("t6_norun", state_o, 0);

    // random phase
    for (int s = 0; s < 400; s++) begin
      int len;
      bit lvl;
      len = $urandom_range(1, 12);
      lvl = 1'($urandom_range(0, 1));
      for (int c = 0; c < len; c++) begin
        start  = lvl;
        up     = ($urandom_range(0, 3) == 0);
        dn     = ($urandom_range(0, 4) == 0);
        row    = ($urandom_range(0, 2) == 0);
        auto_e = ($urandom_range(0, 7) != 0);
        rst_n  = ($urandom_range(0, 299) != 0);
        cyc(1);
      end
    end
    rst_n = 1; start = 0; up = 0; dn = 0; row = 0;
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
